// File: rtl/inv_mix_cols_seq.sv
// Sequential AES InvMixColumns, COLS_PER_CYCLE columns per clock; result valid 4/COLS_PER_CYCLE cycles after accept.
// Result is held in DONE until ready_i; no new input until IDLE. INV_MIX_COLS_FWD_EN adds fwd_i (forward MixColumns).
module inv_mix_cols_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] data_i,
`ifdef INV_MIX_COLS_FWD_EN
    input  logic         fwd_i,
`endif
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] data_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_q;
    state_t       state_d;
    logic [1:0]   cnt_q;
    logic [127:0] work_q;
    logic [127:0] work_d;
    logic         fwd_q;
    logic         load;
    logic         last;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // k is a 4-bit constant: accumulate b*2^i for each set bit i along the xtime chain
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] acc;
        p   = b;
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (k[i])
                acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Both matrices are circulant: row r uses the first-row coefficient at index (j - r) mod 4
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic fwd);
        logic [15:0] k;
        logic [31:0] o;
        k = fwd ? 16'h2311 : 16'hebd9;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                o[31-8*r -: 8] = o[31-8*r -: 8]
                               ^ gmul(col[31-8*j -: 8], k[15-4*((j-r+4)%4) -: 4]);
        return o;
    endfunction

    assign last   = (int'(cnt_q) + COLS_PER_CYCLE) >= 4;
    assign data_o = work_q;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last)
                    state_d = DONE;
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        work_d = work_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++)
            work_d[127-32*((int'(cnt_q)+k)%4) -: 32] =
                mix_col(work_q[127-32*((int'(cnt_q)+k)%4) -: 32], fwd_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            work_q <= data_i;
            cnt_q  <= '0;
        end else if (state_q == BUSY) begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 2'(COLS_PER_CYCLE);
        end
    end

`ifdef INV_MIX_COLS_FWD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fwd_q <= 1'b0;
        else if (load)
            fwd_q <= fwd_i;
    end
`else
    assign fwd_q = 1'b0;
`endif

endmodule
